board_scanner: RTL and testbench

// - Streams the board in raster order, one cell bit per pixel, as the cell_alive input of the VGA renderer.
// - Reads packed board words from the shared board BRAM ahead of the beam.
// - Raises done_out while it needs no memory, so the updater can use the port.

---
 rtl/board_scanner_pkg.sv | 35 +++
 rtl/board_scanner_if.sv | 11 +
 rtl/board_scanner.sv | 151 +++++++++++++++
 tb/tb_board_scanner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/board_scanner_pkg.sv
// Shared widths, types and address helper for the board scanner.
// Row 0 of the board is word addresses 0..WORDS_PER_ROW-1, bit i of a word is cell x = k*WORD_WIDTH+i.
package board_scanner_pkg;

  localparam int unsigned BOARD_SIZE    = 480;
  localparam int unsigned WORD_WIDTH    = 16;
  localparam int unsigned RD_LATENCY    = 2;
  localparam int unsigned H_TOTAL       = 800;
  localparam int unsigned V_TOTAL       = 524;
  localparam int unsigned PREFETCH_H    = 700;
  localparam int unsigned WORDS_PER_ROW = BOARD_SIZE / WORD_WIDTH;
  localparam int unsigned ADDR_W        = $clog2(BOARD_SIZE * BOARD_SIZE / WORD_WIDTH);
  localparam int unsigned HCOUNT_W      = 11;
  localparam int unsigned VCOUNT_W      = 10;
  localparam int unsigned WIDX_W        = $clog2(WORD_WIDTH);
  localparam int unsigned WORD_IDX_W    = HCOUNT_W - WIDX_W;

  typedef logic [HCOUNT_W-1:0]   hcount_t;
  typedef logic [VCOUNT_W-1:0]   vcount_t;
  typedef logic [ADDR_W-1:0]     board_addr_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_STREAM} state_e;
  typedef enum logic {TAG_CUR, TAG_NXT} tag_e;

  typedef struct packed {
    logic valid;
    tag_e tag;
  } slot_t;

  function automatic board_addr_t row_base(input vcount_t row);
    return board_addr_t'(row) * board_addr_t'(WORDS_PER_ROW);
  endfunction

endpackage

// File: rtl/board_scanner_if.sv
// Read port of the shared board BRAM as seen by the scanner (master) and the memory (slave).
interface board_scanner_if;
  import board_scanner_pkg::*;

  logic        mem_rd_out;
  board_addr_t mem_addr_out;
  word_t       mem_data_in;

  modport master (output mem_rd_out, output mem_addr_out, input mem_data_in);
  modport slave  (input mem_rd_out, input mem_addr_out, output mem_data_in);
endinterface

// File: rtl/board_scanner.sv
// Streams board cells to the renderer in raster order, fetching packed words one word ahead of the beam.
// done_out is high whenever the memory port is free for the updater.
module board_scanner
  import board_scanner_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  hcount_t         hcount_in,
  input  vcount_t         vcount_in,
  board_scanner_if.master mem,
  output logic            cell_alive_out,
  output logic            done_out
);

  state_e      r_state;
  word_t       r_cur;
  word_t       r_nxt;
  logic        r_row_valid;
  board_addr_t r_row_base;
  logic        r_last_row;
  logic        r_drain;
  logic        r_rd;
  tag_e        r_rd_tag;
  board_addr_t r_addr;
  logic        r_done;
  slot_t       r_pipe [RD_LATENCY];

  logic                  w_has_target;
  vcount_t               w_target;
  logic                  w_at_prefetch;
  logic [WORD_IDX_W-1:0] w_word_idx;
  logic [WIDX_W-1:0]     w_bit;
  logic                  w_issue_nxt;
  logic                  w_row_end;
  logic                  w_word_end;
  logic                  w_busy;
  slot_t                 w_ret;

  // Row to fetch when the beam reaches the prefetch column of the current line.
  always_comb begin
    w_has_target = 1'b0;
    w_target     = '0;
    if (vcount_in == VCOUNT_W'(V_TOTAL - 1)) begin
      w_has_target = 1'b1;
    end else if (32'(vcount_in) + 32'd1 < 32'(BOARD_SIZE)) begin
      w_has_target = 1'b1;
      w_target     = vcount_in + VCOUNT_W'(1);
    end
  end

  assign w_word_idx    = hcount_in[HCOUNT_W-1:WIDX_W];
  assign w_bit         = hcount_in[WIDX_W-1:0];
  assign w_at_prefetch = (hcount_in == HCOUNT_W'(PREFETCH_H));
  assign w_issue_nxt   = (r_state == S_STREAM) && (w_bit == '0)
                         && (w_word_idx < WORD_IDX_W'(WORDS_PER_ROW - 1));
  assign w_row_end     = (r_state == S_STREAM) && (hcount_in == HCOUNT_W'(BOARD_SIZE - 1));
  // Gated to the visible part so blanking columns with matching low bits cannot clobber cur.
  assign w_word_end    = (&w_bit) && (hcount_in < HCOUNT_W'(BOARD_SIZE));
  assign w_ret         = r_pipe[RD_LATENCY-1];

  always_comb begin
    w_busy = r_rd;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_busy = w_busy | r_pipe[i].valid;
    end
  end

  assign cell_alive_out   = r_row_valid
                            && (hcount_in < HCOUNT_W'(BOARD_SIZE))
                            && (vcount_in < VCOUNT_W'(BOARD_SIZE))
                            && r_cur[w_bit];
  assign mem.mem_rd_out   = r_rd;
  assign mem.mem_addr_out = r_addr;
  assign done_out         = r_done;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_nxt       <= '0;
      r_row_valid <= 1'b0;
      r_row_base  <= '0;
      r_last_row  <= 1'b0;
      r_drain     <= 1'b0;
      r_rd        <= 1'b0;
      r_rd_tag    <= TAG_CUR;
      r_addr      <= '0;
      r_done      <= 1'b1;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe[i] <= '{valid: 1'b0, tag: TAG_CUR};
      end
    end else begin
      r_rd      <= 1'b0;
      r_pipe[0] <= '{valid: r_rd, tag: r_rd_tag};
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      // Data is only trusted in the slot that lines up with its strobe.
      if (w_ret.valid) begin
        if (w_ret.tag == TAG_CUR) r_cur <= mem.mem_data_in;
        else                      r_nxt <= mem.mem_data_in;
      end

      if (hcount_in == HCOUNT_W'(BOARD_SIZE)) r_row_valid <= 1'b0;

      if (r_drain && !w_busy) begin
        r_done  <= 1'b1;
        r_drain <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_at_prefetch && w_has_target) begin
            r_rd       <= 1'b1;
            r_rd_tag   <= TAG_CUR;
            r_addr     <= row_base(w_target);
            r_row_base <= row_base(w_target);
            r_last_row <= (w_target == VCOUNT_W'(BOARD_SIZE - 1));
            r_done     <= 1'b0;
            r_drain    <= 1'b0;
            r_state    <= S_PREFETCH;
          end
        end
        S_PREFETCH: begin
          if (w_ret.valid && (w_ret.tag == TAG_CUR)) begin
            r_row_valid <= 1'b1;
            r_state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_issue_nxt) begin
            r_rd     <= 1'b1;
            r_rd_tag <= TAG_NXT;
            r_addr   <= r_row_base + board_addr_t'(w_word_idx) + board_addr_t'(1);
          end
          if (w_word_end) r_cur <= r_nxt;
          if (w_row_end) begin
            r_state <= S_IDLE;
            if (r_last_row) begin
              if (w_busy) r_drain <= 1'b1;
              else        r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// Directed raster sweeps over chosen lines of the frame, checked every cycle against a pixel/read model
// plus literal expectations at the notable beam positions.
module tb_board_scanner;
  import board_scanner_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  hcount_t hcount = '0;
  vcount_t vcount = '0;
  logic    cell_alive;
  logic    done;

  always #5 clk = ~clk;

  board_scanner_if bus();

  board_scanner dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .mem           (bus),
    .cell_alive_out(cell_alive),
    .done_out      (done)
  );

  int n_vec   = 0;
  int n_bad   = 0;
  int pulses5 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at v=%0d h=%0d", name, act, exp, vcount, hcount);
    end
  endtask

  // Board contents: row 0 is an alternating pattern, every other word holds its own address.
  function automatic word_t ref_word(input int addr);
    return (addr < int'(WORDS_PER_ROW)) ? 16'hAAAA : word_t'(addr);
  endfunction

  function automatic logic ref_cell(input int v, input int h);
    word_t w;
    w = ref_word(v * int'(WORDS_PER_ROW) + h / int'(WORD_WIDTH));
    return w[h % int'(WORD_WIDTH)];
  endfunction

  // Memory model and per-cycle reference: which row is on screen, which reads must appear, done state.
  logic hrd   [RD_LATENCY];
  int   haddr [RD_LATENCY];
  logic armed    = 1'b0;
  logic mv       = 1'b0;
  int   mrow     = 0;
  logic exp_rd   = 1'b0;
  int   exp_addr = 0;
  logic exp_done = 1'b1;

  initial begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      hrd[i]   = 1'b0;
      haddr[i] = 0;
    end
  end

  always @(negedge clk) begin : model
    word_t junk;
    int    v;
    int    h;
    logic  has_tgt;
    int    tgt;
    logic  exp_cell;
    v    = int'(vcount);
    h    = int'(hcount);
    junk = word_t'($urandom());
    bus.mem_data_in = hrd[RD_LATENCY-1] ? ref_word(haddr[RD_LATENCY-1]) : junk;
    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      hrd[i]   = hrd[i-1];
      haddr[i] = haddr[i-1];
    end
    hrd[0]   = bus.mem_rd_out;
    haddr[0] = int'(bus.mem_addr_out);

    if (armed) begin
      check("rd_strobe", 32'(bus.mem_rd_out), 32'(exp_rd));
      if (exp_rd) check("rd_addr", 32'(bus.mem_addr_out), 32'(exp_addr));
      if (bus.mem_rd_out === 1'b1)
        check("addr_range", 32'(int'(bus.mem_addr_out) < int'(BOARD_SIZE * BOARD_SIZE / WORD_WIDTH)), 32'd1);
      check("done", 32'(done), 32'(exp_done));
      if (!rst) begin
        exp_cell = mv && (v == mrow) && (h < int'(BOARD_SIZE)) && (v < int'(BOARD_SIZE)) && ref_cell(v, h);
        check("cell", 32'(cell_alive), 32'(exp_cell));
      end
    end

    has_tgt = 1'b0;
    tgt     = 0;
    if (v == int'(V_TOTAL) - 1) has_tgt = 1'b1;
    else if (v + 1 < int'(BOARD_SIZE)) begin
      has_tgt = 1'b1;
      tgt     = v + 1;
    end

    if (rst) begin
      armed    = 1'b1;
      mv       = 1'b0;
      exp_rd   = 1'b0;
      exp_done = 1'b1;
    end else begin
      exp_rd = 1'b0;
      if (h == int'(PREFETCH_H) && has_tgt) begin
        exp_rd   = 1'b1;
        exp_addr = tgt * int'(WORDS_PER_ROW);
        exp_done = 1'b0;
        mv       = 1'b1;
        mrow     = tgt;
      end else if (mv && v == mrow && h < int'(BOARD_SIZE - WORD_WIDTH) && h % int'(WORD_WIDTH) == 0) begin
        exp_rd   = 1'b1;
        exp_addr = mrow * int'(WORDS_PER_ROW) + h / int'(WORD_WIDTH) + 1;
      end
      if (mv && mrow == int'(BOARD_SIZE) - 1 && v == mrow && h == int'(BOARD_SIZE) - 1) exp_done = 1'b1;
    end
  end

  task automatic tick(input int v, input int h, input logic r);
    @(posedge clk);
    #1;
    vcount = vcount_t'(v);
    hcount = hcount_t'(h);
    rst    = r;
    @(negedge clk);
  endtask

  // Hand-computed expectations at specific beam positions.
  task automatic lit_checks(input int v, input int h);
    if (v == 0 && h < 16) check("row0_alt", 32'(cell_alive), 32'(h % 2));
    if (v == 0 && h >= 480 && h < 500) check("row0_tail", 32'(cell_alive), 32'd0);
    if (v == 0 && h == 479) check("row0_w29_b15", 32'(cell_alive), 32'd1);
    if (v == 4 && h == 701) begin
      check("pf_row5_rd", 32'(bus.mem_rd_out), 32'd1);
      check("pf_row5_addr", 32'(bus.mem_addr_out), 32'd150);
    end
    if (v == 5 && h >= 1 && h <= 480 && bus.mem_rd_out === 1'b1) begin
      pulses5++;
      check("row5_addr", 32'(bus.mem_addr_out), 32'(151 + (h - 1) / 16));
    end
    if (v == 5 && h == 464) check("row5_w29_b0", 32'(cell_alive), 32'd1);
    if (v == 5 && h == 479) check("row5_w29_b15", 32'(cell_alive), 32'd0);
    if (v >= 480 && v <= 522) begin
      check("vblank_rd", 32'(bus.mem_rd_out), 32'd0);
      check("vblank_cell", 32'(cell_alive), 32'd0);
      check("vblank_done", 32'(done), 32'd1);
    end
    if (v == 523 && h == 700) check("done_before_pf0", 32'(done), 32'd1);
    if (v == 523 && h == 701) check("done_after_pf0", 32'(done), 32'd0);
    if (v == 479 && h == 479) check("done_last_row", 32'(done), 32'd0);
    if (v == 479 && h == 480) check("done_rise", 32'(done), 32'd1);
    if (v == 200 && h == 301) begin
      check("rst_rd", 32'(bus.mem_rd_out), 32'd0);
      check("rst_done", 32'(done), 32'd1);
      check("rst_cell", 32'(cell_alive), 32'd0);
    end
    if (v == 201 && h == 0) check("row201_b0", 32'(cell_alive), 32'd0);
    if (v == 201 && h == 1) begin
      check("row201_cell_b1", 32'(cell_alive), 32'd1);
      check("row201_rd", 32'(bus.mem_rd_out), 32'd1);
      check("row201_addr", 32'(bus.mem_addr_out), 32'd6031);
    end
  endtask

  task automatic run_seg(input int v, input int lo, input int hi);
    for (int h = lo; h <= hi; h++) begin
      tick(v, h, 1'b0);
      lit_checks(v, h);
    end
  endtask

  initial begin
    bus.mem_data_in = '0;
    for (int i = 0; i < 3; i++) tick(0, 0, 1'b1);
    tick(523, 600, 1'b0);
    check("reset_rd", 32'(bus.mem_rd_out), 32'd0);
    check("reset_done", 32'(done), 32'd1);
    check("reset_cell", 32'(cell_alive), 32'd0);

    run_seg(523, 601, int'(H_TOTAL) - 1);
    for (int v = 0; v <= 5; v++) run_seg(v, 0, int'(H_TOTAL) - 1);
    check("row5_pulses", 32'(pulses5), 32'd29);
    run_seg(6, 0, 499);

    run_seg(197, 690, int'(H_TOTAL) - 1);
    run_seg(198, 0, int'(H_TOTAL) - 1);
    run_seg(199, 0, int'(H_TOTAL) - 1);
    run_seg(200, 0, 299);
    tick(200, 300, 1'b1);
    lit_checks(200, 300);
    run_seg(200, 301, int'(H_TOTAL) - 1);
    run_seg(201, 0, int'(H_TOTAL) - 1);
    run_seg(202, 0, 499);

    run_seg(476, 690, int'(H_TOTAL) - 1);
    for (int v = 477; v <= 480; v++) run_seg(v, 0, int'(H_TOTAL) - 1);
    for (int v = 481; v <= 521; v++) begin
      run_seg(v, 470, 490);
      run_seg(v, 695, 710);
    end
    run_seg(522, 0, int'(H_TOTAL) - 1);
    run_seg(523, 600, int'(H_TOTAL) - 1);
    run_seg(0, 0, 499);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
